// File: rtl/signal_selector.sv
// rtl/signal_selector.sv - channel selector with blanked settle period on every switch
module signal_selector #(
   parameter int DATA_WIDTH    = 16,
   parameter int CHANNEL_COUNT = 4,
   parameter int SETTLE_CYCLES = 8,
   localparam int SW = $clog2(CHANNEL_COUNT)
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic [SW-1:0]                   sel,
   input  logic                            hold_mode,
   input  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0]           data_out,
   output logic [SW-1:0]                   active_ch,
   output logic                            settling,
   output logic [7:0]                      switch_count
);

   typedef enum logic {
      S_RUN    = 1'b0,
      S_SETTLE = 1'b1
   } state_t;

   localparam int        NUM_CODES = 1 << SW;
   localparam logic [7:0] C_RELOAD = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;

   state_t                 r_state;
   logic [SW-1:0]          r_target;
   logic [7:0]             r_counter;
   logic [SW-1:0]          r_active_ch;
   logic [DATA_WIDTH-1:0]  r_data_out;
   logic                   r_settling;
   logic [7:0]             r_switch_count;

   logic [DATA_WIDTH-1:0]  w_ch [CHANNEL_COUNT];
   logic [NUM_CODES-1:0]   w_valid_mask;
   logic                   w_sel_valid;
   logic [DATA_WIDTH-1:0]  w_blank;

   // Unpack channels and mark which sel codes name a real channel
   for (genvar gi = 0; gi < CHANNEL_COUNT; gi++) begin : g_unpack
      assign w_ch[gi] = data_in[gi*DATA_WIDTH +: DATA_WIDTH];
   end
   for (genvar gv = 0; gv < NUM_CODES; gv++) begin : g_valid
      assign w_valid_mask[gv] = (gv < CHANNEL_COUNT);
   end

   assign w_sel_valid = w_valid_mask[sel];
   assign w_blank     = hold_mode ? r_data_out : '0;

   // Selector FSM: routes the active channel in RUN, blanks output while settling
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state        <= S_RUN;
         r_target       <= '0;
         r_counter      <= 8'd0;
         r_active_ch    <= '0;
         r_data_out     <= '0;
         r_settling     <= 1'b0;
         r_switch_count <= 8'd0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (w_sel_valid && (sel != r_active_ch)) begin
                  if (SETTLE_CYCLES == 0) begin
                     r_active_ch    <= sel;
                     r_data_out     <= w_ch[sel];
                     r_switch_count <= r_switch_count + 8'd1;
                  end else begin
                     r_state    <= S_SETTLE;
                     r_target   <= sel;
                     r_counter  <= C_RELOAD;
                     r_settling <= 1'b1;
                     r_data_out <= w_blank;
                  end
               end else begin
                  r_data_out <= w_ch[r_active_ch];
               end
            end
            S_SETTLE: begin
               if (w_sel_valid && (sel != r_target)) begin
                  // A new request restarts the full settle window
                  r_target   <= sel;
                  r_counter  <= C_RELOAD;
                  r_data_out <= w_blank;
               end else if (r_counter == 8'd0) begin
                  r_state        <= S_RUN;
                  r_active_ch    <= r_target;
                  r_settling     <= 1'b0;
                  r_data_out     <= w_ch[r_target];
                  r_switch_count <= r_switch_count + 8'd1;
               end else begin
                  r_counter  <= r_counter - 8'd1;
                  r_data_out <= w_blank;
               end
            end
            default: begin
               r_state <= S_RUN;
            end
         endcase
      end
   end

   assign data_out     = r_data_out;
   assign active_ch    = r_active_ch;
   assign settling     = r_settling;
   assign switch_count = r_switch_count;

endmodule
